hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It keeps a shadow pipeline of destination register, data kind and Tnew for the E, M and W stages, and runs a multiply/divide busy counter. From these it produces the D-stage forwarding selects (`frsd`/`frtd`, driving the ID-stage 8-way muxes), the E-stage forwarding selects, and the single `stall` that freezes F/D and inserts a bubble into E.

---
 rtl/hazard_pkg.sv | 57 +++++
 rtl/hazard_ctrl_fwd_sel.sv | 51 +++++
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: result kinds,
// forwarding select encodings, default MD latencies and the shadow stage record.
package hazard_pkg;

    localparam int REG_W = 5;

    // Result kind of an instruction, as delivered on kindd.
    typedef enum logic [1:0] {
        K_LINK = 2'd0,   // pc+8 written to a register (jal/jalr)
        K_ALU  = 2'd1,   // ALU result
        K_LOAD = 2'd2    // memory read result
    } kind_e;

    // D-stage select codes; order matches the ID-stage mux8 inputs.
    localparam logic [2:0] DSEL_GRF  = 3'd0;
    localparam logic [2:0] DSEL_PC8E = 3'd1;
    localparam logic [2:0] DSEL_ALUM = 3'd2;
    localparam logic [2:0] DSEL_PC8M = 3'd3;
    localparam logic [2:0] DSEL_RESW = 3'd4;

    // E-stage select codes.
    localparam logic [1:0] ESEL_DE   = 2'd0;
    localparam logic [1:0] ESEL_ALUM = 2'd1;
    localparam logic [1:0] ESEL_PC8M = 2'd2;
    localparam logic [1:0] ESEL_RESW = 2'd3;

    // Default multiply/divide latencies after the op leaves E.
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // One shadow pipeline stage.
    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic [1:0]       kind;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             md_start;
        logic             md_div;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    // Cycles until the result is available, counted from the E stage.
    function automatic logic [1:0] tnew_e(input logic [1:0] kind);
        case (kind)
            K_LINK:  tnew_e = 2'd0;
            K_LOAD:  tnew_e = 2'd2;
            default: tnew_e = 2'd1;
        endcase
    endfunction

    // Cycles until the result is available, counted from the M stage.
    function automatic logic [1:0] tnew_m(input logic [1:0] kind);
        tnew_m = (kind == K_LOAD) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand D-stage forwarding resolution: picks the youngest producer
// among E/M/W and decides whether the operand must stall.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] addr,
    input  logic [1:0]       tuse,
    input  stage_t           st_e,
    input  stage_t           st_m,
    input  stage_t           st_w,
    output logic [2:0]       dsel,
    output logic             stall_op
);

    logic hit_e;
    logic hit_m;
    logic hit_w;

    // Register zero is hard-wired, so it never forwards or stalls.
    assign hit_e = (addr != '0) && (addr == st_e.dst);
    assign hit_m = (addr != '0) && (addr == st_m.dst);
    assign hit_w = (addr != '0) && (addr == st_w.dst);

    // Fields carried in the shadow stages that operand selection never looks at.
    logic unused_fields;
    assign unused_fields = ^{st_e.rs, st_e.rt, st_e.md_start, st_e.md_div,
                             st_m.rs, st_m.rt, st_m.md_start, st_m.md_div,
                             st_w.kind, st_w.rs, st_w.rt, st_w.md_start, st_w.md_div};

    // Youngest matching stage decides the select and any stall.
    always_comb begin
        dsel     = DSEL_GRF;
        stall_op = 1'b0;
        if (hit_e) begin
            if (st_e.kind == K_LINK) begin
                dsel = DSEL_PC8E;
            end else begin
                stall_op = (tnew_e(st_e.kind) > tuse);
            end
        end else if (hit_m) begin
            case (st_m.kind)
                K_LINK: dsel = DSEL_PC8M;
                K_LOAD: stall_op = (tnew_m(st_m.kind) > tuse);
                default: dsel = DSEL_ALUM;
            endcase
        end else if (hit_w) begin
            dsel = DSEL_RESW;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow E/M/W pipeline, multiply/divide busy
// counter, D- and E-stage forwarding selects and the global stall.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rsd,
    input  logic [REG_W-1:0] rtd,
    input  logic [1:0]       tuse_rs,
    input  logic [1:0]       tuse_rt,
    input  logic [REG_W-1:0] dstd,
    input  logic [1:0]       kindd,
    input  logic             md_startd,
    input  logic             md_divd,
    input  logic             md_used,
    output logic             stall,
    output logic [2:0]       frsd,
    output logic [2:0]       frtd,
    output logic [1:0]       frse,
    output logic [1:0]       frte
);

    localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    stage_t e_reg;
    stage_t m_reg;
    stage_t w_reg;
    stage_t e_next;

    logic [CNT_W-1:0] mdcnt_reg;
    logic [CNT_W-1:0] mdcnt_next;

    logic stall_rs;
    logic stall_rt;
    logic md_busy;

    // Instruction entering E: the D instruction, or a bubble while stalled.
    always_comb begin
        e_next = BUBBLE;
        if (!stall) begin
            e_next.dst      = dstd;
            e_next.kind     = kindd;
            e_next.rs       = rsd;
            e_next.rt       = rtd;
            e_next.md_start = md_startd;
            e_next.md_div   = md_startd & md_divd;
        end
    end

    // MD counter loads when an op sits in E, otherwise drains to zero.
    always_comb begin
        mdcnt_next = mdcnt_reg;
        if (e_reg.md_start) begin
            mdcnt_next = e_reg.md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (mdcnt_reg != '0) begin
            mdcnt_next = mdcnt_reg - CNT_W'(1);
        end
    end

    // Shadow pipeline and MD counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_reg     <= BUBBLE;
            m_reg     <= BUBBLE;
            w_reg     <= BUBBLE;
            mdcnt_reg <= '0;
        end else begin
            e_reg     <= e_next;
            m_reg     <= e_reg;
            w_reg     <= m_reg;
            mdcnt_reg <= mdcnt_next;
        end
    end

    fwd_sel u_fwd_rs (
        .addr     (rsd),
        .tuse     (tuse_rs),
        .st_e     (e_reg),
        .st_m     (m_reg),
        .st_w     (w_reg),
        .dsel     (frsd),
        .stall_op (stall_rs)
    );

    fwd_sel u_fwd_rt (
        .addr     (rtd),
        .tuse     (tuse_rt),
        .st_e     (e_reg),
        .st_m     (m_reg),
        .st_w     (w_reg),
        .dsel     (frtd),
        .stall_op (stall_rt)
    );

    assign md_busy = e_reg.md_start | (mdcnt_reg != '0);
    assign stall   = stall_rs | stall_rt | (md_used & md_busy);

    // E-stage selects; a load in M never reaches here un-stalled, so only
    // link and ALU producers in M are considered.
    function automatic logic [1:0] esel(input logic [REG_W-1:0] a,
                                        input stage_t sm,
                                        input stage_t sw);
        esel = ESEL_DE;
        if ((a != '0) && (a == sm.dst)) begin
            esel = (sm.kind == K_LINK) ? ESEL_PC8M : ESEL_ALUM;
        end else if ((a != '0) && (a == sw.dst)) begin
            esel = ESEL_RESW;
        end
    endfunction

    // E-stage forwarding for the instruction currently in E.
    always_comb begin
        frse = esel(e_reg.rs, m_reg, w_reg);
        frte = esel(e_reg.rt, m_reg, w_reg);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: dependency stalls, forwarding selects,
// MD busy stalls and reset recovery, each checked against hand-computed values.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsd, rtd, dstd;
    logic [1:0] tuse_rs, tuse_rt, kindd;
    logic       md_startd, md_divd, md_used;
    logic       stall;
    logic [2:0] frsd, frtd;
    logic [1:0] frse, frte;

    int total = 0;
    int bad   = 0;
    int cnt;

    hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .rsd       (rsd),
        .rtd       (rtd),
        .tuse_rs   (tuse_rs),
        .tuse_rt   (tuse_rt),
        .dstd      (dstd),
        .kindd     (kindd),
        .md_startd (md_startd),
        .md_divd   (md_divd),
        .md_used   (md_used),
        .stall     (stall),
        .frsd      (frsd),
        .frtd      (frtd),
        .frse      (frse),
        .frte      (frte)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
        $display("check %s: got %0d want %0d", tag, obs, exp);
    endtask

    // Drive the D-stage instruction.
    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] trs, input logic [1:0] trt,
                         input logic [4:0] dst, input logic [1:0] kind,
                         input logic mds, input logic mdd, input logic mdu);
        rsd = rs; rtd = rt; tuse_rs = trs; tuse_rt = trt;
        dstd = dst; kindd = kind; md_startd = mds; md_divd = mdd; md_used = mdu;
        #1;
    endtask

    task automatic nop();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        nop();
        repeat (4) tick();
    endtask

    // Count consecutive stall cycles, bounded so the run always ends.
    task automatic count_stall(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!stall) break;
            n++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        nop();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_stall", stall, 0);
        check("rst_frsd", frsd, 0);
        check("rst_frtd", frtd, 0);
        check("rst_frse", frse, 0);
        check("rst_frte", frte, 0);

        // ALU result into a branch
        set_d(5'd1, 5'd2, 2'd3, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        check("alu_prod_nostall", stall, 0);
        tick();
        set_d(5'd3, 5'd0, 2'd0, 2'd3, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        check("alu_br_stall", stall, 1);
        tick();
        check("alu_br_release", stall, 0);
        check("alu_br_frsd", frsd, 2);
        tick();
        nop();
        check("alu_br_frse", frse, 3);
        flush();

        // Load into an ALU op (tuse 1)
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd5, 2'd3, 2'd1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
        check("ld_alu_stall", stall, 1);
        tick();
        check("ld_alu_release", stall, 0);
        check("ld_alu_frtd", frtd, 0);
        tick();
        nop();
        check("ld_alu_frte", frte, 3);
        flush();

        // Load into a branch (tuse 0): two stall cycles then W forward
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        count_stall(cnt);
        check("ld_br_cycles", 8'(cnt), 2);
        check("ld_br_frsd", frsd, 4);
        flush();

        // Link forwarding from E then M
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        check("link_e_stall", stall, 0);
        check("link_e_frsd", frsd, 1);
        tick();
        check("link_m_stall", stall, 0);
        check("link_m_frsd", frsd, 3);
        check("link_m_frse", frse, 2);
        flush();

        // Register zero never matches
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        check("r0_stall", stall, 0);
        check("r0_frsd", frsd, 0);
        flush();

        // Two operands from different stages
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd4, 5'd6, 2'd1, 2'd1, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        check("both_stall", stall, 0);
        check("both_frsd", frsd, 2);
        check("both_frtd", frtd, 1);
        flush();

        // Youngest producer wins (ALU in E over link in M)
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd7, 5'd0, 2'd1, 2'd3, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        check("young_stall", stall, 0);
        check("young_frsd", frsd, 0);
        flush();

        // Divide followed by mflo
        set_d(5'd0, 5'd0, 2'd1, 2'd1, 5'd0, 2'd1, 1'b1, 1'b1, 1'b1);
        check("div_issue_stall", stall, 0);
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b1);
        count_stall(cnt);
        check("div_cycles", 8'(cnt), 11);
        check("div_mdcnt_end", 8'(dut.mdcnt_reg), 0);
        flush();

        // Multiply followed by mflo
        set_d(5'd0, 5'd0, 2'd1, 2'd1, 5'd0, 2'd1, 1'b1, 1'b0, 1'b1);
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b1);
        count_stall(cnt);
        check("mult_cycles", 8'(cnt), 6);
        flush();

        // Reset in the middle of a divide
        set_d(5'd0, 5'd0, 2'd1, 2'd1, 5'd0, 2'd1, 1'b1, 1'b1, 1'b1);
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        check("rdiv_stall", stall, 1);
        check("rdiv_mdcnt", 8'(dut.mdcnt_reg), 7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rdiv_post_mdcnt", 8'(dut.mdcnt_reg), 0);
        check("rdiv_post_stall", stall, 0);
        check("rdiv_post_frsd", frsd, 0);
        check("rdiv_post_frtd", frtd, 0);
        check("rdiv_post_frse", frse, 0);
        check("rdiv_post_frte", frte, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
